// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU: forwarding select encodings,
// controller state type and the in-flight destination tag record.
package cpu_pkg;

   localparam logic [1:0] FWD_REGF  = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;

   // Tags hold a zero-extended register index so any REG_ADDR_W up to this fits.
   localparam int unsigned TAG_DST_W = 8;

   typedef struct packed {
      logic                 wr;
      logic                 load;
      logic [TAG_DST_W-1:0] dst;
   } tag_t;

   function automatic logic tag_match(input tag_t t, input logic [TAG_DST_W-1:0] src);
      return t.wr && (t.dst != '0) && (t.dst == src);
   endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Three-entry destination tag shift register (EX, MEM, WB) with bubble insert
// into EX and a synchronous clear of all entries.
module hazard_tag_pipe
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic Reset_n,
   input  logic clear,
   input  logic bubble,
   input  tag_t id_tag,
   output tag_t ex_tag,
   output tag_t mem_tag,
   output tag_t wb_tag
);

   always_ff @(posedge clk) begin
      if (!Reset_n || clear) begin
         ex_tag  <= '0;
         mem_tag <= '0;
         wb_tag  <= '0;
      end else begin
         wb_tag  <= mem_tag;
         mem_tag <= ex_tag;
         ex_tag  <= bubble ? '0 : id_tag;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stalls, flushes,
// ALU forwarding selects. Define HAZARD_STORE_FWD_EN to forward load data to SW.
module pipeline_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  Reset_n,
   input  logic                  LoadInstructions,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_is_store,
   input  logic [REG_ADDR_W-1:0] id_dst,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_taken,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  fwd_store_sel,
   output logic [CNT_W-1:0]      stall_count
);

   state_t state, state_nxt;
   tag_t   ex_tag, mem_tag, wb_tag, id_tag;
   logic   run, rs_dep, rt_dep, rt_stall_dep, load_use, stall;
   logic   [TAG_DST_W-1:0] rs_x, rt_x;

   function automatic logic [1:0] fwd_pick(input tag_t ex_t, input tag_t mem_t,
                                           input logic [TAG_DST_W-1:0] src, input logic used);
      if (used && tag_match(ex_t, src)) return FWD_EXMEM;
      if (used && tag_match(mem_t, src)) return FWD_MEMWB;
      return FWD_REGF;
   endfunction

   assign rs_x = TAG_DST_W'(id_rs);
   assign rt_x = TAG_DST_W'(id_rt);
   assign run  = (state == ST_RUN);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = LoadInstructions ? ST_LOAD : ST_RUN;
         ST_LOAD: if (!LoadInstructions) state_nxt = ST_IDLE;
         ST_RUN:  if (LoadInstructions) state_nxt = ST_LOAD;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   assign id_tag = '{wr:   id_valid & id_reg_write,
                     load: id_valid & id_mem_read,
                     dst:  TAG_DST_W'(id_dst)};

   assign rs_dep = id_valid & id_uses_rs & tag_match(ex_tag, rs_x);
   assign rt_dep = id_valid & id_uses_rt & tag_match(ex_tag, rt_x);

`ifdef HAZARD_STORE_FWD_EN
   // Store data of SW is only needed in MEM, so the loaded value can be bypassed there.
   logic store_fwd, store_fwd_ex;
   assign store_fwd    = rt_dep & id_is_store & ex_tag.load;
   assign rt_stall_dep = rt_dep & ~id_is_store;
`else
   assign rt_stall_dep = rt_dep;
   assign fwd_store_sel = 1'b0;
`endif

   assign load_use = ex_tag.load & (rs_dep | rt_stall_dep);
   assign stall    = run & load_use & ~ex_branch_taken;

   always_comb begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      if (run) begin
         if (ex_branch_taken) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
         end else if (stall) begin
            ifid_flush    = 1'b0;
         end else begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b0;
            idex_bubble   = 1'b0;
         end
      end
   end

   hazard_tag_pipe u_tags (
      .clk     (clk),
      .Reset_n (Reset_n),
      .clear   (~run | LoadInstructions),
      .bubble  (idex_bubble),
      .id_tag  (id_tag),
      .ex_tag  (ex_tag),
      .mem_tag (mem_tag),
      .wb_tag  (wb_tag)
   );

   always_ff @(posedge clk) begin
      if (!Reset_n || !run || LoadInstructions) begin
         fwd_a_sel <= FWD_REGF;
         fwd_b_sel <= FWD_REGF;
      end else if (stall) begin
         fwd_a_sel <= fwd_a_sel;
         fwd_b_sel <= fwd_b_sel;
      end else if (idex_bubble) begin
         fwd_a_sel <= FWD_REGF;
         fwd_b_sel <= FWD_REGF;
      end else begin
         fwd_a_sel <= fwd_pick(ex_tag, mem_tag, rs_x, id_valid & id_uses_rs);
         fwd_b_sel <= fwd_pick(ex_tag, mem_tag, rt_x, id_valid & id_uses_rt);
      end
   end

`ifdef HAZARD_STORE_FWD_EN
   // Flag follows the SW from EX into MEM.
   always_ff @(posedge clk) begin
      if (!Reset_n || !run || LoadInstructions) begin
         store_fwd_ex  <= 1'b0;
         fwd_store_sel <= 1'b0;
      end else begin
         store_fwd_ex  <= idex_bubble ? 1'b0 : store_fwd;
         fwd_store_sel <= store_fwd_ex;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         stall_count <= '0;
      end else if (!run && state_nxt == ST_RUN) begin
         stall_count <= '0;
      end else if (stall && stall_count != '1) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl plus hand-written
// sequences for store forwarding, reset during a stall and reload during RUN.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned AW    = 5;
   localparam int unsigned CNT_W = 16;

   localparam logic [3:0] RUNC = 4'b1100; // {pc_we, ifid_we, flush, bubble}
   localparam logic [3:0] STL  = 4'b0001;
   localparam logic [3:0] BRC  = 4'b1111;
   localparam logic [3:0] IDL  = 4'b0011;

   typedef struct {
      logic          ld, v;
      logic [AW-1:0] rs, rt;
      logic          urs, urt, st;
      logic [AW-1:0] dst;
      logic          rw, mr, br;
      logic [3:0]    ctl;
      logic [1:0]    fa, fb;
      logic          fs;
      int            cnt;
   } vec_t;

   logic clk, Reset_n, LoadInstructions, id_valid;
   logic [AW-1:0] id_rs, id_rt, id_dst;
   logic id_uses_rs, id_uses_rt, id_is_store, id_reg_write, id_mem_read, ex_branch_taken;
   logic pc_write_en, ifid_write_en, ifid_flush, idex_bubble, fwd_store_sel;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [CNT_W-1:0] stall_count;

   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[23];
   vec_t t;

   pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .Reset_n          (Reset_n),
      .LoadInstructions (LoadInstructions),
      .id_valid         (id_valid),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rs       (id_uses_rs),
      .id_uses_rt       (id_uses_rt),
      .id_is_store      (id_is_store),
      .id_dst           (id_dst),
      .id_reg_write     (id_reg_write),
      .id_mem_read      (id_mem_read),
      .ex_branch_taken  (ex_branch_taken),
      .pc_write_en      (pc_write_en),
      .ifid_write_en    (ifid_write_en),
      .ifid_flush       (ifid_flush),
      .idex_bubble      (idex_bubble),
      .fwd_a_sel        (fwd_a_sel),
      .fwd_b_sel        (fwd_b_sel),
      .fwd_store_sel    (fwd_store_sel),
      .stall_count      (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t ins(input int rs, input int rt, input bit urs, input bit urt,
                                input bit st, input int dst, input bit rw, input bit mr,
                                input bit br, input logic [3:0] ctl, input logic [1:0] fa,
                                input logic [1:0] fb, input int cnt);
      vec_t r;
      r.ld = 1'b0; r.v = 1'b1;
      r.rs = AW'(rs); r.rt = AW'(rt); r.urs = urs; r.urt = urt; r.st = st;
      r.dst = AW'(dst); r.rw = rw; r.mr = mr; r.br = br;
      r.ctl = ctl; r.fa = fa; r.fb = fb; r.fs = 1'b0; r.cnt = cnt;
      return r;
   endfunction

   function automatic vec_t nop(input logic [3:0] ctl, input logic [1:0] fa,
                                input logic [1:0] fb, input int cnt);
      vec_t r;
      r = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, fa, fb, cnt);
      r.v = 1'b0;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      LoadInstructions = v.ld; id_valid = v.v;
      id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
      id_is_store = v.st; id_dst = v.dst; id_reg_write = v.rw; id_mem_read = v.mr;
      ex_branch_taken = v.br;
   endtask

   task automatic chk(input int id, input vec_t v);
      logic [3:0] a;
      a = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble};
      n_chk++;
      if (a !== v.ctl || fwd_a_sel !== v.fa || fwd_b_sel !== v.fb ||
          fwd_store_sel !== v.fs || stall_count !== CNT_W'(v.cnt)) begin
         n_fail++;
         $display("FAIL step %0d: ctl/fa/fb/fs/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                  id, a, fwd_a_sel, fwd_b_sel, fwd_store_sel, stall_count,
                  v.ctl, v.fa, v.fb, v.fs, v.cnt);
      end
   endtask

   // Drive at the falling edge, compare once combinational outputs settle.
   task automatic step(input int id, input vec_t v, input logic rstn);
      @(negedge clk);
      Reset_n = rstn;
      drive(v);
      #2;
      chk(id, v);
   endtask

   initial begin
      // Expected fwd values are those of the instruction currently in EX,
      // i.e. computed from the previous row's ID fields.
      tbl[0]  = nop(IDL, 0, 0, 0);
      tbl[1]  = ins(0, 0, 1, 0, 0, 1, 1, 0, 0, RUNC, 0, 0, 0);   // addi R1
      tbl[2]  = ins(0, 0, 1, 0, 0, 2, 1, 0, 0, RUNC, 0, 0, 0);
      tbl[3]  = ins(0, 0, 1, 0, 0, 3, 1, 0, 0, RUNC, 0, 0, 0);
      tbl[4]  = ins(0, 0, 1, 0, 0, 4, 1, 0, 0, RUNC, 0, 0, 0);
      tbl[5]  = ins(0, 0, 1, 0, 0, 5, 1, 0, 0, RUNC, 0, 0, 0);   // addi R5
      tbl[6]  = ins(1, 5, 1, 1, 0, 5, 1, 0, 0, RUNC, 0, 0, 0);   // add R5,R1,R5
      tbl[7]  = ins(5, 0, 1, 0, 0, 5, 1, 0, 0, RUNC, 0, 1, 0);   // addi R5,R5,5
      tbl[8]  = ins(0, 0, 1, 0, 0, 3, 1, 0, 0, RUNC, 1, 0, 0);   // addi R3
      tbl[9]  = ins(0, 0, 1, 0, 0, 2, 1, 0, 0, RUNC, 0, 0, 0);   // addi R2
      tbl[10] = ins(1, 3, 1, 1, 0, 6, 1, 0, 0, RUNC, 0, 0, 0);   // add R6,R1,R3
      tbl[11] = ins(2, 1, 1, 1, 0, 6, 1, 0, 0, RUNC, 0, 2, 0);   // add R6,R2,R1
      tbl[12] = ins(6, 1, 1, 1, 0, 7, 1, 0, 0, RUNC, 2, 0, 0);   // add R7,R6,R1
      tbl[13] = ins(7, 7, 1, 1, 0, 9, 0, 0, 0, RUNC, 1, 0, 0);   // beq, no write
      tbl[14] = ins(9, 9, 1, 1, 0, 10, 1, 0, 0, RUNC, 1, 1, 0);  // reads beq dst
      tbl[15] = ins(1, 2, 1, 1, 0, 0, 1, 0, 0, RUNC, 0, 0, 0);   // add R0,R1,R2
      tbl[16] = ins(0, 0, 1, 1, 0, 11, 1, 0, 0, RUNC, 0, 0, 0);  // reads R0
      tbl[17] = ins(2, 0, 1, 0, 0, 1, 1, 1, 0, RUNC, 0, 0, 0);   // lw R1,10(R2)
      tbl[18] = ins(1, 3, 1, 1, 0, 6, 1, 0, 0, STL, 0, 0, 0);    // add R6,R1,R3 stalls
      tbl[19] = ins(1, 3, 1, 1, 0, 6, 1, 0, 0, RUNC, 0, 0, 1);
      tbl[20] = ins(0, 0, 1, 0, 0, 4, 1, 1, 0, RUNC, 2, 0, 1);   // lw R4
      tbl[21] = ins(4, 4, 1, 1, 0, 5, 1, 0, 1, BRC, 0, 0, 1);    // load-use + branch
      tbl[22] = nop(RUNC, 0, 0, 1);

      Reset_n = 1'b0;
      drive(nop(IDL, 0, 0, 0));
      repeat (2) @(posedge clk);
      step(90, nop(IDL, 0, 0, 0), 1'b0);
      t = nop(IDL, 0, 0, 0); t.ld = 1'b1;
      step(91, t, 1'b1);                         // IDLE, load requested
      step(92, t, 1'b1);                         // LOAD
      step(93, nop(IDL, 0, 0, 0), 1'b1);         // LOAD, load done

      for (int i = 0; i < 23; i++) step(i, tbl[i], 1'b1);

      // lw R1 then sw R1,0(R4)
      step(101, ins(2, 0, 1, 0, 0, 1, 1, 1, 0, RUNC, 0, 0, 1), 1'b1);
`ifdef HAZARD_STORE_FWD_EN
      step(102, ins(4, 1, 1, 1, 1, 0, 0, 0, 0, RUNC, 0, 0, 1), 1'b1);
      step(103, nop(RUNC, 0, 1, 1), 1'b1);
      t = nop(RUNC, 0, 0, 1); t.fs = 1'b1;
      step(104, t, 1'b1);
      step(105, ins(2, 0, 1, 0, 0, 1, 1, 1, 0, RUNC, 0, 0, 1), 1'b1);
      step(106, ins(1, 3, 1, 1, 0, 6, 1, 0, 0, STL, 0, 0, 1), 1'b0);
`else
      step(102, ins(4, 1, 1, 1, 1, 0, 0, 0, 0, STL, 0, 0, 1), 1'b1);
      step(107, ins(4, 1, 1, 1, 1, 0, 0, 0, 0, RUNC, 0, 0, 2), 1'b1);
      step(103, nop(RUNC, 0, 2, 2), 1'b1);
      step(104, nop(RUNC, 0, 0, 2), 1'b1);
      step(105, ins(2, 0, 1, 0, 0, 1, 1, 1, 0, RUNC, 0, 0, 2), 1'b1);
      step(106, ins(1, 3, 1, 1, 0, 6, 1, 0, 0, STL, 0, 0, 2), 1'b0);
`endif
      // Reset taken during the stall
      step(110, nop(IDL, 0, 0, 0), 1'b0);
      step(111, nop(IDL, 0, 0, 0), 1'b1);
      step(112, ins(0, 0, 1, 0, 0, 1, 1, 0, 0, RUNC, 0, 0, 0), 1'b1);
      // Reload requested while a dependent add sits in ID
      t = ins(1, 1, 1, 1, 0, 2, 1, 0, 0, RUNC, 0, 0, 0); t.ld = 1'b1;
      step(113, t, 1'b1);
      step(114, ins(1, 1, 1, 1, 0, 2, 1, 0, 0, IDL, 0, 0, 0), 1'b1);
      step(115, nop(IDL, 0, 0, 0), 1'b1);
      step(116, ins(1, 1, 1, 1, 0, 2, 1, 0, 0, RUNC, 0, 0, 0), 1'b1);
      step(117, nop(RUNC, 0, 0, 0), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
